// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the mips_mem memory responder and loader.
// Optional feature macro: LOAD_SUM_EN (adds the ld_sum checksum output).
package mips_mem_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned IMEM_AW = 6;

   typedef enum logic [1:0] {
      LD_LOAD,
      LD_ZERO,
      LD_RUN
   } ld_state_e;

   // Big-endian lane placement: byte 0 of a word lands in [31:24].
   function automatic logic [WORD_W-1:0] place_byte(input logic [1:0]        pos,
                                                    input logic [BYTE_W-1:0] b);
      logic [WORD_W-1:0] w;
      case (pos)
         2'd0:    w = {b, 24'h000000};
         2'd1:    w = {8'h00, b, 16'h0000};
         2'd2:    w = {16'h0000, b, 8'h00};
         default: w = {24'h000000, b};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mips_mem_loader.sv
// Program loader: packs the byte stream into imem words, zero-fills the tail
// and holds the core in reset until done. LOAD_SUM_EN adds ld_sum.
module mips_mem_loader
   import mips_mem_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ld_valid,
   input  logic [BYTE_W-1:0]   ld_data,
   input  logic                ld_last,
   output logic                ld_ready,
   output logic                imem_we,
   output logic [IMEM_AW-1:0]  imem_idx,
   output logic [WORD_W-1:0]   imem_wdata,
   output logic                core_rst,
   output logic                ld_done
`ifdef LOAD_SUM_EN
   ,
   output logic [BYTE_W-1:0]   ld_sum
`endif
);

   localparam int unsigned CNT_W = $clog2(4 * IMEM_WORDS);

   ld_state_e          state_q, state_d;
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [IMEM_AW-1:0] word_idx_q, word_idx_d;
   logic [WORD_W-1:0]  word_buf_q, word_buf_d;
`ifdef LOAD_SUM_EN
   logic [BYTE_W-1:0]  sum_q, sum_d;
`endif

   logic               hs;
   logic               last_eff;
   logic               word_full;
   logic               idx_max;
   logic [WORD_W-1:0]  merged;

   always_comb begin
      ld_ready   = rst_n && (state_q == LD_LOAD);
      hs         = ld_valid && ld_ready;
      last_eff   = ld_last || (byte_cnt_q == CNT_W'(4 * IMEM_WORDS - 1));
      word_full  = (byte_cnt_q[1:0] == 2'd3);
      idx_max    = (word_idx_q == IMEM_AW'(IMEM_WORDS - 1));
      // Held bytes sit in the upper lanes with zeros below, so a short final
      // word comes out already padded.
      merged     = word_buf_q | place_byte(byte_cnt_q[1:0], ld_data);

      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_idx_d = word_idx_q;
      word_buf_d = word_buf_q;
      imem_we    = 1'b0;
      imem_wdata = '0;
`ifdef LOAD_SUM_EN
      sum_d      = sum_q;
`endif

      case (state_q)
         LD_LOAD: begin
            if (hs) begin
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
`ifdef LOAD_SUM_EN
               sum_d      = sum_q + ld_data;
`endif
               if (word_full || last_eff) begin
                  imem_we    = 1'b1;
                  imem_wdata = merged;
                  word_buf_d = '0;
                  word_idx_d = word_idx_q + IMEM_AW'(1);
                  if (last_eff) begin
                     state_d = idx_max ? LD_RUN : LD_ZERO;
                  end
               end else begin
                  word_buf_d = merged;
               end
            end
         end
         LD_ZERO: begin
            imem_we    = 1'b1;
            word_idx_d = word_idx_q + IMEM_AW'(1);
            if (idx_max) begin
               state_d = LD_RUN;
            end
         end
         default: ;
      endcase

      imem_we  = imem_we && rst_n;
      imem_idx = word_idx_q;
      core_rst = !rst_n || (state_q != LD_RUN);
      ld_done  = rst_n && (state_q == LD_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= LD_LOAD;
         byte_cnt_q <= '0;
         word_idx_q <= '0;
         word_buf_q <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_idx_q <= word_idx_d;
         word_buf_q <= word_buf_d;
      end
   end

`ifdef LOAD_SUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign ld_sum = sum_q;
`endif

endmodule

// File: rtl/mips_mem.sv
// Memory side of the mips core: imem/dmem arrays with registered reads plus
// the boot loader. LOAD_SUM_EN exposes the loader byte checksum on ld_sum.
module mips_mem
   import mips_mem_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned DMEM_BYTES = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        mem_i_addr,
   output logic [31:0]       mem_i,
   input  logic [7:0]        mem_rw_addr,
   output logic [7:0]        mem_r,
   input  logic [7:0]        mem_w,
   input  logic              mem_w_en,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              core_rst,
   output logic              ld_done
`ifdef LOAD_SUM_EN
   ,
   output logic [7:0]        ld_sum
`endif
);

   logic [WORD_W-1:0] imem [IMEM_WORDS];
   logic [BYTE_W-1:0] dmem [DMEM_BYTES];

   logic               imem_we;
   logic [IMEM_AW-1:0] imem_idx;
   logic [WORD_W-1:0]  imem_wdata;

   logic [WORD_W-1:0]  mem_i_q, mem_i_d;
   logic [BYTE_W-1:0]  mem_r_q, mem_r_d;
   logic [1:0]         unused_addr_bits;

   mips_mem_loader #(
      .IMEM_WORDS (IMEM_WORDS)
   ) u_loader (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .imem_we    (imem_we),
      .imem_idx   (imem_idx),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .ld_done    (ld_done)
`ifdef LOAD_SUM_EN
      ,
      .ld_sum     (ld_sum)
`endif
   );

   assign unused_addr_bits = mem_i_addr[1:0];

   always_comb begin
      mem_i_d = ld_done ? imem[mem_i_addr[7:2]] : '0;
      mem_r_d = dmem[mem_rw_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_i_q <= '0;
         mem_r_q <= '0;
      end else begin
         mem_i_q <= mem_i_d;
         mem_r_q <= mem_r_d;
      end
   end

   // Arrays carry no reset: dmem must survive a reboot of the core.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         imem[imem_idx] <= imem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_w_en && ld_done) begin
         dmem[mem_rw_addr] <= mem_w;
      end
   end

   assign mem_i = mem_i_q;
   assign mem_r = mem_r_q;

endmodule

// File: tb/tb_mips_mem.sv
// Directed bench for mips_mem: load, zero-fill, overflow, data port and
// mid-load reset, with hand-computed expectations.
module tb_mips_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  mem_i_addr;
   logic [31:0] mem_i;
   logic [7:0]  mem_rw_addr;
   logic [7:0]  mem_r;
   logic [7:0]  mem_w;
   logic        mem_w_en;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        core_rst;
   logic        ld_done;
`ifdef LOAD_SUM_EN
   logic [7:0]  ld_sum;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          cnt;

   always #5 clk = ~clk;

   mips_mem #(
      .IMEM_WORDS (64),
      .DMEM_BYTES (256)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_i_addr  (mem_i_addr),
      .mem_i       (mem_i),
      .mem_rw_addr (mem_rw_addr),
      .mem_r       (mem_r),
      .mem_w       (mem_w),
      .mem_w_en    (mem_w_en),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .core_rst    (core_rst),
      .ld_done     (ld_done)
`ifdef LOAD_SUM_EN
      ,
      .ld_sum      (ld_sum)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      mem_w_en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input logic last, input int gap);
      ld_valid = 1'b1;
      ld_data  = b;
      ld_last  = last;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_run(output int cycles);
      cycles = 0;
      while (core_rst && cycles < 300) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic fetch(input string tag, input logic [7:0] a, input logic [31:0] exp);
      mem_i_addr = a;
      @(negedge clk);
      check(tag, mem_i, exp);
   endtask

   task automatic dread(input string tag, input logic [7:0] a, input logic [7:0] exp);
      mem_rw_addr = a;
      @(negedge clk);
      check(tag, {24'h0, mem_r}, {24'h0, exp});
   endtask

   task automatic dwrite(input logic [7:0] a, input logic [7:0] d);
      mem_rw_addr = a;
      mem_w       = d;
      mem_w_en    = 1'b1;
      @(negedge clk);
      mem_w_en    = 1'b0;
   endtask

   logic [7:0] img1 [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] img2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      mem_i_addr  = '0;
      mem_rw_addr = '0;
      mem_w       = '0;
      mem_w_en    = 1'b0;
      ld_valid    = 1'b0;
      ld_data     = '0;
      ld_last     = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_core_rst", {31'h0, core_rst}, 32'd1);
      check("rst_ld_ready", {31'h0, ld_ready}, 32'd0);
      check("rst_ld_done",  {31'h0, ld_done},  32'd0);
      check("rst_mem_i",    mem_i, 32'h0);
      check("rst_mem_r",    {24'h0, mem_r}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("load_ready", {31'h0, ld_ready}, 32'd1);

      // Scenario 1: 8-byte image, last at word 1 -> 62 zero-fill cycles
      for (int i = 0; i < 8; i++) send(img1[i], i == 7, 0);
      check("s1_zero_ready", {31'h0, ld_ready}, 32'd0);
      check("s1_zero_core_rst", {31'h0, core_rst}, 32'd1);
      mem_i_addr = 8'h00;
      wait_run(cnt);
      check("s1_run_latency", cnt, 32'd62);
      check("s1_mem_i_prerun", mem_i, 32'h0);
      check("s1_ld_done", {31'h0, ld_done}, 32'd1);
      fetch("s1_w0", 8'h00, 32'h20010005);
      fetch("s1_w0_unaligned", 8'h03, 32'h20010005);
      for (int w = 1; w < 64; w++) fetch("s1_zero_fill", 8'(w * 4), 32'h0);

      // Data port: read-during-write returns the old byte
      dwrite(8'h10, 8'h33);
      mem_rw_addr = 8'h10;
      mem_w       = 8'h5A;
      mem_w_en    = 1'b1;
      @(negedge clk);
      check("rdw_old", {24'h0, mem_r}, 32'h33);
      mem_w_en = 1'b0;
      @(negedge clk);
      check("wr_visible", {24'h0, mem_r}, 32'h5A);
      dwrite(8'h11, 8'hC3);
      dread("neighbour_keep", 8'h10, 8'h5A);
      dread("neighbour_wr", 8'h11, 8'hC3);

      // Scenario 2: 5 bytes, with write attempts to dmem during the load
      do_reset();
      mem_rw_addr = 8'h10;
      mem_w       = 8'hFF;
      mem_w_en    = 1'b1;
      for (int i = 0; i < 5; i++) send(img2[i], i == 4, 0);
      mem_w_en = 1'b0;
      mem_i_addr = 8'h00;
      wait_run(cnt);
      check("s2_run_latency", cnt, 32'd62);
      fetch("s2_w0", 8'h00, 32'hAABBCCDD);
      fetch("s2_w1_pad", 8'h04, 32'hEE000000);
      fetch("s2_w2", 8'h08, 32'h0);
      dread("s2_dmem_kept", 8'h10, 8'h5A);
`ifdef LOAD_SUM_EN
      // 0xAA+0xBB+0xCC+0xDD+0xEE = 0x3FC
      check("s2_sum", {24'h0, ld_sum}, 32'hFC);
`endif

      // Scenario 3: scenario 1 with valid pulsing 1-0-0
      do_reset();
      for (int i = 0; i < 8; i++) send(img1[i], i == 7, 2);
      wait_run(cnt);
      // Two idle cycles after the last byte already elapsed inside send
      check("s3_run_latency", cnt, 32'd60);
      fetch("s3_w0", 8'h00, 32'h20010005);
      fetch("s3_w1", 8'h04, 32'h0);
      fetch("s3_w63", 8'hFC, 32'h0);

      // Scenario 4: 256 bytes, no ld_last -> straight to run
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send(8'(i), 1'b0, 0);
         if (i == 254) check("s4_pre_last_core_rst", {31'h0, core_rst}, 32'd1);
      end
      wait_run(cnt);
      check("s4_run_latency", cnt, 32'd0);
      check("s4_ld_ready", {31'h0, ld_ready}, 32'd0);
      ld_valid = 1'b1;
      ld_data  = 8'h99;
      ld_last  = 1'b1;
      @(negedge clk);
      check("s4_257th_ready", {31'h0, ld_ready}, 32'd0);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      fetch("s4_w0", 8'h00, 32'h00010203);
      fetch("s4_w1", 8'h04, 32'h04050607);
      fetch("s4_w31", 8'h7C, 32'h7C7D7E7F);
      fetch("s4_w63", 8'hFC, 32'hFCFDFEFF);
`ifdef LOAD_SUM_EN
      check("s4_sum", {24'h0, ld_sum}, 32'h80);
`endif

      // Scenario 5: reset after 6 bytes, reload a single word
      do_reset();
      for (int i = 0; i < 6; i++) send(8'(8'h11 + i), 1'b0, 0);
      rst_n       = 1'b0;
      mem_rw_addr = 8'h10;
      mem_w       = 8'hEE;
      mem_w_en    = 1'b1;
      @(negedge clk);
      check("s5_rst_core_rst", {31'h0, core_rst}, 32'd1);
      check("s5_rst_ld_ready", {31'h0, ld_ready}, 32'd0);
      check("s5_rst_ld_done",  {31'h0, ld_done},  32'd0);
      @(negedge clk);
      mem_w_en = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 4; i++) send(8'(i + 1), i == 3, 0);
      wait_run(cnt);
      check("s5_run_latency", cnt, 32'd63);
      fetch("s5_w0", 8'h00, 32'h01020304);
      fetch("s5_w1", 8'h04, 32'h0);
      dread("s5_dmem_kept", 8'h10, 8'h5A);
`ifdef LOAD_SUM_EN
      check("s5_sum", {24'h0, ld_sum}, 32'h0A);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
